unity_syndrome_check: RTL and testbench

UNITY_SYNDROME_CHECK -- requirements
Module: unity_syndrome_check

---
 rtl/unity_syndrome_check.sv | 68 ++++++
 tb/tb_unity_syndrome_check.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/unity_syndrome_check.sv
// Two-symbol GF(2^8) syndrome (S0, S1) over a 10-symbol codeword, poly 0x11D, alpha=0x02.
// Define SYNDROME_CHECK_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module unity_syndrome_check (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [79:0] codeword_in,
  output logic [15:0] syndrome_out,
  output logic        error_flag_out,
  output logic        out_valid
);

  localparam int DATA_W = 8;
  localparam int SYMS   = 10;

  // Multiply by alpha: shift left, fold bit 7 back through the low terms of 0x11D.
  function automatic logic [DATA_W-1:0] mul_alpha(input logic [DATA_W-1:0] a);
    mul_alpha = {a[DATA_W-2:0], 1'b0} ^ (a[DATA_W-1] ? 8'h1D : 8'h00);
  endfunction

  logic [DATA_W*SYMS-1:0] codeword_p0;
  logic                   vld_p0;

`ifdef SYNDROME_CHECK_IN_REG_EN
  // Stage p0: registered input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codeword_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      codeword_p0 <= codeword_in;
      vld_p0      <= in_valid;
    end
  end
`else
  assign codeword_p0 = codeword_in;
  assign vld_p0      = in_valid;
`endif

  logic [DATA_W-1:0] s0_p0;
  logic [DATA_W-1:0] s1_p0;

  // Horner form for S1: each step is one fixed XOR network for the alpha multiply.
  always_comb begin
    s0_p0 = '0;
    s1_p0 = '0;
    for (int i = SYMS - 1; i >= 0; i--) begin
      s0_p0 = s0_p0 ^ codeword_p0[i*DATA_W +: DATA_W];
      s1_p0 = mul_alpha(s1_p0) ^ codeword_p0[i*DATA_W +: DATA_W];
    end
  end

  // Stage p1: registered syndrome, flag and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syndrome_out   <= '0;
      error_flag_out <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      out_valid <= vld_p0;
      if (vld_p0) begin
        syndrome_out   <= {s0_p0, s1_p0};
        error_flag_out <= |{s0_p0, s1_p0};
      end
    end
  end

endmodule

// File: tb/tb_unity_syndrome_check.sv
// Directed, table-driven bench for unity_syndrome_check; adapts to SYNDROME_CHECK_IN_REG_EN.
module tb_unity_syndrome_check;

`ifdef SYNDROME_CHECK_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [79:0] codeword_in;
  logic [15:0] syndrome_out;
  logic        error_flag_out;
  logic        out_valid;

  unity_syndrome_check dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .codeword_in    (codeword_in),
    .syndrome_out   (syndrome_out),
    .error_flag_out (error_flag_out),
    .out_valid      (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [79:0] cw;
    logic [15:0] syn;
    logic        flag;
    string       name;
  } vec_t;

  vec_t vecs[8];

  // Drive one codeword for a single cycle, check the result at the latency point and the hold after.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    codeword_in = v.cw;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    codeword_in = '1;
    repeat (LAT - 1) @(negedge clk);
    chk({v.name, "_vld"},  {31'd0, out_valid}, 32'd1);
    chk({v.name, "_syn"},  {16'd0, syndrome_out}, {16'd0, v.syn});
    chk({v.name, "_flag"}, {31'd0, error_flag_out}, {31'd0, v.flag});
    @(negedge clk);
    chk({v.name, "_vld_lo"},   {31'd0, out_valid}, 32'd0);
    chk({v.name, "_syn_hold"}, {16'd0, syndrome_out}, {16'd0, v.syn});
  endtask

  logic [15:0] smp_syn[6];
  logic        smp_flag[6];
  logic        smp_vld[6];

  initial begin
    vecs[0] = '{80'h0,                                  16'h0000, 1'b0, "zero"};
    vecs[1] = '{80'h1,                                  16'h0101, 1'b1, "sym0_01"};
    vecs[2] = '{(80'h1 << 72),                          16'h013A, 1'b1, "sym9_01"};
    vecs[3] = '{((80'h1 << 79) | (80'h1 << 61)),        16'hA081, 1'b1, "sym9_80_sym7_20"};
    vecs[4] = '{(80'h1 << 64),                          16'h011D, 1'b1, "sym8_01"};
    vecs[5] = '{(80'hFF << 8),                          16'hFFE3, 1'b1, "sym1_ff"};
    vecs[6] = '{80'h0102,                               16'h0300, 1'b1, "s1_cancel"};
    vecs[7] = '{{10{8'h01}},                            16'h00D8, 1'b1, "all_01"};

    rst         = 1'b1;
    in_valid    = 1'b0;
    codeword_in = '0;
    #2;
    chk("rst_syn",  {16'd0, syndrome_out}, 32'd0);
    chk("rst_flag", {31'd0, error_flag_out}, 32'd0);
    chk("rst_vld",  {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Back-to-back: sym0=01 then zero on consecutive cycles
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      smp_syn[k]  = syndrome_out;
      smp_flag[k] = error_flag_out;
      smp_vld[k]  = out_valid;
      in_valid    = (k < 2);
      codeword_in = (k == 0) ? 80'h1 : 80'h0;
      @(negedge clk);
    end
    for (int k = 1; k < LAT; k++) chk("b2b_pre_vld", {31'd0, smp_vld[k]}, 32'd0);
    chk("b2b_1_vld",  {31'd0, smp_vld[LAT]}, 32'd1);
    chk("b2b_1_syn",  {16'd0, smp_syn[LAT]}, 32'h0101);
    chk("b2b_1_flag", {31'd0, smp_flag[LAT]}, 32'd1);
    chk("b2b_2_vld",  {31'd0, smp_vld[LAT+1]}, 32'd1);
    chk("b2b_2_syn",  {16'd0, smp_syn[LAT+1]}, 32'h0000);
    chk("b2b_2_flag", {31'd0, smp_flag[LAT+1]}, 32'd0);
    chk("b2b_end_vld", {31'd0, smp_vld[LAT+2]}, 32'd0);

    // Asynchronous reset between edges while holding 0xA081
    apply_vec(vecs[3]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_syn",  {16'd0, syndrome_out}, 32'd0);
    chk("arst_flag", {31'd0, error_flag_out}, 32'd0);
    chk("arst_vld",  {31'd0, out_valid}, 32'd0);

    // Codeword presented while reset is held must be dropped
    @(negedge clk);
    codeword_in = 80'h1;
    in_valid    = 1'b1;
    @(negedge clk);
    chk("rst_hold_syn", {16'd0, syndrome_out}, 32'd0);
    in_valid    = 1'b0;
    rst         = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      chk("rst_drop_vld", {31'd0, out_valid}, 32'd0);
      chk("rst_drop_syn", {16'd0, syndrome_out}, 32'd0);
    end

    // First sample after reset release
    apply_vec(vecs[5]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
